instr_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the main decoder in the single-cycle RV32I core.
- Owns the program counter and fetches instructions from instruction memory over a req/ack handshake.
- Presents one instruction at a time, with its PC, to the decode/execute path through a valid/ready handshake.
- Computes the next PC from the decoder's PCSrc output and the immediate-extended branch offset.

---
 rtl/instr_fetch_unit.sv | 93 +++++++++
 tb/tb_instr_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack memory handshake and
// hands one instruction at a time to decode through a valid/ready handshake.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] ImmExt,
  output logic            fetch_fault
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic [XLEN-1:0] next_pc;

  assign imem_addr = pc;
  assign next_pc   = PCSrc ? (pc + ImmExt) : (pc + XLEN'(4));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      instr       <= NOP;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        // An ack in the final allowed wait cycle still wins over the timeout.
        REQ: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            wait_cnt    <= '0;
            state       <= HOLD;
          end else if (wait_cnt == CW'(MAX_WAIT)) begin
            imem_req    <= 1'b0;
            fetch_fault <= 1'b1;
            state       <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        // A misaligned target leaves pc pointing at the offending instruction.
        HOLD: begin
          if (instr_valid && instr_ready) begin
            if (next_pc[1:0] != 2'b00) begin
              instr_valid <= 1'b0;
              fetch_fault <= 1'b1;
              state       <= FAULT;
            end else begin
              pc          <= next_pc;
              instr_valid <= 1'b0;
              imem_req    <= 1'b1;
              state       <= REQ;
            end
          end
        end
        FAULT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          fetch_fault <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run checked
// against a transaction-level model of the PC sequence and instruction memory.
module tb_instr_fetch_unit;

  localparam int MAX_WAIT = 15;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        PCSrc;
  logic [31:0] ImmExt;
  logic        fetch_fault;

  int tests = 0;
  int fails = 0;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .pc(pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .PCSrc(PCSrc),
    .ImmExt(ImmExt), .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Memory contents: an arbitrary fixed word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; PCSrc = 1'b0; ImmExt = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Memory answers the current request after 'delay' idle cycles.
  task automatic respond(input int delay, output bit held);
    logic [31:0] a;
    a = imem_addr;
    held = 1'b1;
    for (int i = 0; i <= delay; i++) begin
      if (imem_req !== 1'b1 || imem_addr !== a) held = 1'b0;
      imem_ack   = (i == delay);
      imem_rdata = (i == delay) ? mem_word(a) : $urandom;
      @(negedge clk);
    end
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic consume(input logic taken, input logic [31:0] imm);
    instr_ready = 1'b1; PCSrc = taken; ImmExt = imm;
    @(negedge clk);
    instr_ready = 1'b0; PCSrc = $urandom_range(0, 1); ImmExt = $urandom | 32'h1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0; PCSrc = 1'b0; ImmExt = '0;
    @(negedge clk);
    tests++; if (pc !== 32'h0 || imem_addr !== 32'h0) begin fails++;
      $display("[TB] FAIL reset_pc: pc=%h addr=%h expected 0", pc, imem_addr); end
    tests++; if (instr !== NOP) begin fails++;
      $display("[TB] FAIL reset_instr: got %h expected %h", instr, NOP); end
    tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || fetch_fault !== 1'b0) begin fails++;
      $display("[TB] FAIL reset_flags: valid=%b req=%b fault=%b expected 0 0 0",
               instr_valid, imem_req, fetch_fault); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++;
      $display("[TB] FAIL first_req: req=%b addr=%h expected 1 0", imem_req, imem_addr); end
  endtask

  task automatic test_first_fetch();
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    @(negedge clk);
    imem_ack = 1'b0;
    tests++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || pc !== 32'h0) begin fails++;
      $display("[TB] FAIL first_fetch: valid=%b instr=%h pc=%h expected 1 00500093 0",
               instr_valid, instr, pc); end
    tests++; if (imem_req !== 1'b0) begin fails++;
      $display("[TB] FAIL first_fetch_req: req=%b expected 0", imem_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    bit held;
    exp = 32'h0;
    for (int k = 0; k < 3; k++) begin
      consume(1'b0, $urandom);
      exp = exp + 32'd4;
      tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || pc !== exp) begin fails++;
        $display("[TB] FAIL seq_gap: valid=%b req=%b pc=%h expected 0 1 %h",
                 instr_valid, imem_req, pc, exp); end
      respond(0, held);
      tests++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== exp
                   || instr !== mem_word(exp)) begin fails++;
        $display("[TB] FAIL seq_fetch: valid=%b req=%b pc=%h instr=%h expected 1 0 %h %h",
                 instr_valid, imem_req, pc, instr, exp, mem_word(exp)); end
    end
  endtask

  task automatic test_branch();
    bit held;
    consume(1'b0, 32'h0);
    respond(0, held);
    tests++; if (pc !== 32'h10) begin fails++;
      $display("[TB] FAIL branch_setup: pc=%h expected 10", pc); end
    consume(1'b1, 32'hFFFF_FFF8);
    tests++; if (imem_addr !== 32'h8 || imem_req !== 1'b1 || fetch_fault !== 1'b0) begin fails++;
      $display("[TB] FAIL branch_back: addr=%h req=%b fault=%b expected 8 1 0",
               imem_addr, imem_req, fetch_fault); end
    respond(2, held);
    tests++; if (!held || instr !== mem_word(32'h8) || pc !== 32'h8) begin fails++;
      $display("[TB] FAIL branch_fetch: held=%b instr=%h pc=%h expected 1 %h 8",
               held, instr, pc, mem_word(32'h8)); end
    consume(1'b0, 32'h0); respond(0, held);
    consume(1'b0, 32'h0); respond(0, held);
    consume(1'b1, 32'h6);
    tests++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h10
                 || instr_valid !== 1'b0) begin fails++;
      $display("[TB] FAIL misalign: fault=%b req=%b pc=%h valid=%b expected 1 0 10 0",
               fetch_fault, imem_req, pc, instr_valid); end
    imem_ack = 1'b1; instr_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    repeat (4) @(negedge clk);
    imem_ack = 1'b0; instr_ready = 1'b0;
    tests++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h10
                 || instr_valid !== 1'b0) begin fails++;
      $display("[TB] FAIL fault_sticky: fault=%b req=%b pc=%h valid=%b expected 1 0 10 0",
               fetch_fault, imem_req, pc, instr_valid); end
  endtask

  task automatic test_timeout();
    bit held;
    bit early;
    do_reset();
    early = 1'b0;
    for (int i = 0; i <= MAX_WAIT; i++) begin
      if (imem_req !== 1'b1 || fetch_fault !== 1'b0) early = 1'b1;
      @(negedge clk);
    end
    tests++; if (early) begin fails++;
      $display("[TB] FAIL timeout_early: fault or req dropped before %0d REQ cycles", MAX_WAIT + 1); end
    tests++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin fails++;
      $display("[TB] FAIL timeout: fault=%b req=%b expected 1 0", fetch_fault, imem_req); end
    do_reset();
    respond(MAX_WAIT, held);
    tests++; if (!held || fetch_fault !== 1'b0 || instr_valid !== 1'b1
                 || instr !== mem_word(32'h0)) begin fails++;
      $display("[TB] FAIL late_ack: held=%b fault=%b valid=%b instr=%h expected 1 0 1 %h",
               held, fetch_fault, instr_valid, instr, mem_word(32'h0)); end
  endtask

  task automatic test_stall();
    bit stable;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; instr_ready = 1'b0;
      @(negedge clk);
      if (instr !== mem_word(32'h0) || pc !== 32'h0 || instr_valid !== 1'b1 || imem_req !== 1'b0)
        stable = 1'b0;
    end
    imem_ack = 1'b0;
    tests++; if (!stable) begin fails++;
      $display("[TB] FAIL stall: instr=%h pc=%h valid=%b req=%b expected %h 0 1 0",
               instr, pc, instr_valid, imem_req, mem_word(32'h0)); end
  endtask

  task automatic test_wrap();
    bit held;
    consume(1'b1, 32'hFFFF_FFFC);
    tests++; if (pc !== 32'hFFFF_FFFC || imem_addr !== 32'hFFFF_FFFC) begin fails++;
      $display("[TB] FAIL wrap_top: pc=%h expected fffffffc", pc); end
    respond(1, held);
    consume(1'b0, 32'h0);
    tests++; if (pc !== 32'h0 || imem_req !== 1'b1 || fetch_fault !== 1'b0) begin fails++;
      $display("[TB] FAIL wrap: pc=%h req=%b fault=%b expected 0 1 0", pc, imem_req, fetch_fault); end
    respond(0, held);
  endtask

  task automatic test_midreset();
    bit held;
    consume(1'b1, 32'h20);
    tests++; if (imem_addr !== 32'h20 || imem_req !== 1'b1) begin fails++;
      $display("[TB] FAIL midreset_setup: addr=%h req=%b expected 20 1", imem_addr, imem_req); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (pc !== 32'h0 || instr !== NOP || instr_valid !== 1'b0 || imem_req !== 1'b0) begin fails++;
      $display("[TB] FAIL async_reset: pc=%h instr=%h valid=%b req=%b expected 0 %h 0 0",
               pc, instr, instr_valid, imem_req, NOP); end
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; instr_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0; instr_ready = 1'b0;
    tests++; if (instr !== NOP || instr_valid !== 1'b0 || imem_req !== 1'b1 || pc !== 32'h0) begin fails++;
      $display("[TB] FAIL stray_ack: instr=%h valid=%b req=%b pc=%h expected %h 0 1 0",
               instr, instr_valid, imem_req, pc, NOP); end
    respond(0, held);
    tests++; if (instr !== mem_word(32'h0) || pc !== 32'h0 || instr_valid !== 1'b1) begin fails++;
      $display("[TB] FAIL refetch: instr=%h pc=%h valid=%b expected %h 0 1",
               instr, pc, instr_valid, mem_word(32'h0)); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] imm;
    logic        taken;
    bit          held;
    int          off;
    do_reset();
    exp_pc = 32'h0;
    for (int n = 0; n < 40; n++) begin
      respond(int'($urandom_range(0, MAX_WAIT)), held);
      tests++; if (!held || instr_valid !== 1'b1 || pc !== exp_pc || instr !== mem_word(exp_pc)
                   || fetch_fault !== 1'b0) begin fails++;
        $display("[TB] FAIL rand_fetch[%0d]: held=%b valid=%b pc=%h instr=%h expected 1 1 %h %h",
                 n, held, instr_valid, pc, instr, exp_pc, mem_word(exp_pc)); end
      repeat ($urandom_range(0, 3)) begin
        imem_ack = $urandom_range(0, 1); imem_rdata = $urandom; instr_ready = 1'b0;
        @(negedge clk);
      end
      imem_ack = 1'b0;
      tests++; if (instr !== mem_word(exp_pc) || pc !== exp_pc || instr_valid !== 1'b1) begin fails++;
        $display("[TB] FAIL rand_stall[%0d]: instr=%h pc=%h valid=%b expected %h %h 1",
                 n, instr, pc, instr_valid, mem_word(exp_pc), exp_pc); end
      taken = $urandom_range(0, 1);
      off = int'($urandom_range(0, 64)) - 32;
      imm = 32'(off * 4);
      consume(taken, imm);
      exp_pc = taken ? exp_pc + imm : exp_pc + 32'd4;
      tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || pc !== exp_pc) begin fails++;
        $display("[TB] FAIL rand_next[%0d]: valid=%b req=%b pc=%h expected 0 1 %h",
                 n, instr_valid, imem_req, pc, exp_pc); end
    end
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; PCSrc = 1'b0; ImmExt = '0;
    test_reset();
    test_first_fetch();
    test_sequential();
    test_branch();
    test_timeout();
    test_stall();
    test_wrap();
    test_midreset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
